// File: rtl/input_capa_search_ctrl_if.sv
// input_capa_search_ctrl_if: bundles the sequencer's handshake and result bus.
// Ports: start/arrival_circ/arrival_test flow from the bench (master) into the
// sequencer (slave); stim, sel_test, capa_test_code, circuit_delay, test_delay,
// result_code, busy, fin_test and timeout_err flow back from the sequencer.
interface input_capa_search_ctrl_if #(
  parameter int CODE_W = 6,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              arrival_circ;
  logic              arrival_test;
  logic              stim;
  logic              sel_test;
  logic [CODE_W-1:0] capa_test_code;
  logic [CNT_W-1:0]  circuit_delay;
  logic [CNT_W-1:0]  test_delay;
  logic [CODE_W-1:0] result_code;
  logic              busy;
  logic              fin_test;
  logic              timeout_err;
  modport master (
    output start, arrival_circ, arrival_test,
    input  stim, sel_test, capa_test_code, circuit_delay, test_delay,
           result_code, busy, fin_test, timeout_err
  );
  modport slave (
    input  start, arrival_circ, arrival_test,
    output stim, sel_test, capa_test_code, circuit_delay, test_delay,
           result_code, busy, fin_test, timeout_err
  );
endinterface

// File: rtl/input_capa_search_ctrl.sv
// input_capa_search_ctrl: times the circuit path, then binary-searches the
// test-capacitor code until the test-path delay matches the circuit-path delay.
// Ports: clk, rst (async, active high), bus (slave side of the control bus):
//   start in, arrival_circ/arrival_test in (already synchronous), stim out,
//   sel_test out, capa_test_code out, circuit_delay/test_delay out,
//   result_code out, busy out, fin_test out (1-cycle pulse), timeout_err out.
module input_capa_search_ctrl #(
  parameter int              CODE_W     = 6,
  parameter int              CNT_W      = 16,
  parameter int              SETTLE_CYC = 8,
  parameter logic [CNT_W-1:0] MAX_CNT   = CNT_W'(16'hFFF0)
) (
  input logic                     clk,
  input logic                     rst,
  input_capa_search_ctrl_if.slave bus
);
  localparam int IDX_W = CODE_W > 1 ? $clog2(CODE_W) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(CODE_W - 1);
  typedef enum logic [2:0] {IDLE, SETTLE, MEAS, DECIDE, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, circ_q, circ_d, test_q, test_d;
  logic [CODE_W-1:0] code_q, code_d, res_q, res_d, bit_sel, kept;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              sel_q, sel_d, terr_q, terr_d;
  logic              flag, settled, tout;
  assign flag    = sel_q ? bus.arrival_test : bus.arrival_circ;
  assign settled = cnt_q == SETTLE_LAST;
  assign tout    = cnt_q == MAX_CNT;
  assign bit_sel = CODE_W'(1) << idx_q;
  // Equal delays keep the trial bit, so the search lands on the largest
  // code whose test delay does not exceed the circuit delay.
  assign kept    = test_q > circ_q ? code_q & ~bit_sel : code_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      circ_q  <= '0;
      test_q  <= '0;
      code_q  <= '0;
      res_q   <= '0;
      idx_q   <= IDX_TOP;
      sel_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      circ_q  <= circ_d;
      test_q  <= test_d;
      code_q  <= code_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      terr_q  <= terr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? SETTLE : IDLE;
      SETTLE:  state_d = settled && !flag ? MEAS : SETTLE;
      MEAS:    state_d = flag ? (sel_q ? DECIDE : SETTLE) : (tout ? ERR : MEAS);
      DECIDE:  state_d = idx_q == '0 ? DONE : SETTLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.stim     = state_q == MEAS;
    bus.busy     = state_q != IDLE;
    bus.fin_test = state_q == DONE || state_q == ERR;
  end
  // One counter serves both phases: cleared on every state change, it
  // saturates at the end of settling so an extended SETTLE cannot wrap, and
  // in MEAS it stops at MAX_CNT because the timeout leaves the state.
  always_comb begin
    cnt_d  = state_d != state_q ? '0 :
             (state_q == MEAS || (state_q == SETTLE && !settled)) ? cnt_q + 1'b1 : cnt_q;
    circ_d = circ_q;
    test_d = test_q;
    code_d = code_q;
    res_d  = res_q;
    idx_d  = idx_q;
    sel_d  = sel_q;
    terr_d = terr_q;
    if (state_q == IDLE && bus.start) begin
      terr_d = 1'b0;
      sel_d  = 1'b0;
      code_d = '0;
      idx_d  = IDX_TOP;
    end
    if (state_q == MEAS && flag && !sel_q) begin
      circ_d = cnt_q;
      sel_d  = 1'b1;
      code_d = CODE_W'(1) << (CODE_W - 1);
    end
    if (state_q == MEAS && flag && sel_q) test_d = cnt_q;
    if (state_q == MEAS && !flag && tout) begin
      terr_d = 1'b1;
      res_d  = '0;
    end
    if (state_q == DECIDE) begin
      code_d = kept | (bit_sel >> 1);
      idx_d  = idx_q == '0 ? idx_q : idx_q - 1'b1;
      res_d  = idx_q == '0 ? kept : res_q;
    end
  end
  assign bus.sel_test       = sel_q;
  assign bus.capa_test_code = code_q;
  assign bus.circuit_delay  = circ_q;
  assign bus.test_delay     = test_q;
  assign bus.result_code    = res_q;
  assign bus.timeout_err    = terr_q;
endmodule

// File: doc/input_capa_search_ctrl.md
Name: input_capa_search_ctrl

Overview:
- Digital sequencer for the input-capacitance characterization bench.
- Drives the input edge onto the cell under test and times the arrival of the circuit path (real load). It then binary-searches the test-capacitor code until the test-path delay matches the circuit-path delay.
- Reports both delays and the matched code, and pulses fin_test at the end of each characterization.

Parameters:
- CODE_W, 6: width of the test-capacitor code; equals the number of search trials.
- CNT_W, 16: width of the delay counter.
- SETTLE_CYC, 8: cycles with stim low before each measurement, for discharge and settling.
- MAX_CNT, 16'hFFF0: delay count at which a measurement is declared timed out.

Ports:
- clk  input  1  bench clock; one clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; accepted only in IDLE.
- arrival_circ  input  1  threshold-crossing flag of the circuit path; already synchronous to clk.
- arrival_test  input  1  threshold-crossing flag of the test path; already synchronous to clk.
- stim  output  1  input edge to the cell; high during measurement.
- sel_test  output  1  path select: 0 = circuit path, 1 = test path.
- capa_test_code  output  CODE_W  current test-capacitor code.
- circuit_delay  output  CNT_W  latched circuit-path delay, in cycles.
- test_delay  output  CNT_W  latched delay of the most recent test trial.
- result_code  output  CODE_W  final matched code.
- busy  output  1  high in any state other than IDLE.
- fin_test  output  1  one-cycle end-of-test pulse.
- timeout_err  output  1  sticky; cleared on the next accepted start.

Behaviour:
- Reset values: every output is 0, the state is IDLE, and the internal bit index is CODE_W-1.
- rst asserted mid-operation: immediate return to IDLE with all outputs 0. No fin_test pulse is generated.

States:
- IDLE:
  - busy=0.
  - start=1 → SETTLE. In the same transition: timeout_err cleared, sel_test=0, capa_test_code=0, bit index=CODE_W-1.
  - start=0 → remain in IDLE.
- SETTLE:
  - stim=0. The settle counter runs from 0.
  - Exit requires both: SETTLE_CYC cycles elapsed, and the selected arrival flag low.
  - If the flag stays high, SETTLE is extended indefinitely.
  - Exit goes to MEAS.
- MEAS:
  - stim=1. The delay counter cleared to 0 on entry and increments every cycle.
  - Let N be the counter value at the first clock edge where the selected arrival flag is sampled high. When the flag rises N cycles after stim rises, the latched delay is N.
  - sel_test=0 → circuit_delay=N, then go to SETTLE with sel_test=1 and capa_test_code = 1<<(CODE_W-1).
  - sel_test=1 → test_delay=N, then go to DECIDE.
  - Counter reaches MAX_CNT before arrival → ERR.
- DECIDE (one cycle, stim=0):
  - test_delay > circuit_delay → clear bit[idx]; otherwise keep it.
  - idx > 0 → set bit[idx-1], decrement idx, go to SETTLE.
  - idx == 0 → result_code = resulting code, go to DONE.
  - Equal delays count as keep, so result_code is the largest code whose test_delay ≤ circuit_delay.
- DONE: fin_test=1 for exactly one cycle, then IDLE. busy drops the cycle after fin_test.
- ERR: stim=0, timeout_err=1, result_code=0, fin_test pulses for one cycle, then IDLE.

Timing and width rules:
- circuit_delay and test_delay hold their values until overwritten.
- A full run comprises CODE_W+1 measurements.
- start is ignored while busy=1.
- Comparison is unsigned, CNT_W wide. The delay counter never wraps; MAX_CNT terminates the measurement first.

Test Plan:
1. Binary search (CODE_W=4). Circuit arrival 20 cycles after stim. Test arrival = 3*code+5 cycles.
   - Required code sequence: 8, 4, 6, 5.
   - Required outputs: result_code=5, circuit_delay=20, final test_delay=20, one fin_test pulse, timeout_err=0.
2. Boundaries (CODE_W=4). Circuit arrival at 100 cycles, test path at 3*code+5.
   - Required: result_code=15 (all bits kept).
   - Rerun with circuit arrival at 2 cycles. Required: result_code=0.
3. Timeout. MAX_CNT=64 and arrival_test never rises.
   - Required: ERR, timeout_err=1, result_code=0, fin_test pulse, stim low.
   - Issue the next start. Required: timeout_err clears.
4. Settle hold. arrival_circ held high for 30 cycles after start (SETTLE_CYC=8).
   - Required: stim stays 0 until the cycle after arrival_circ falls.
5. Reset mid-run. rst pulsed during the third trial's MEAS.
   - Required: all outputs 0 immediately, no fin_test.
   - A subsequent start completes normally.
6. start during busy. Repeated start pulses mid-run.
   - Required: ignored, exactly one fin_test per accepted start, and busy=1 throughout the run.
